instr_fetch_unit: RTL

//  Producer side of the instruction path: owns the fetch PC and runs the request/ack handshake to

---
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, runs the single-outstanding req/ack
// handshake to instruction memory and buffers fetched words in a small prefetch queue.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              req_q;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]       instr_q [DEPTH];
  logic [31:0]       pc_q    [DEPTH];
  logic              push;
  logic              pop;

  // Fetch FSM: an ack arriving in IDLE is a protocol error and has no effect.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect && (count_q < FULL)) begin
          state_d = WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_d = IDLE;
          push    = !redirect;
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = redirect_pc & ~32'h0000_0003;
    else if (push) fetch_pc_d = fetch_pc_q + 32'd4;
  end

  // Queue bookkeeping: a redirect wipes the queue and cancels any same-cycle push or pop.
  assign pop = (count_q != '0) && instr_ready && !redirect;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= (state_d != IDLE);
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      pc_q[wr_ptr_q]    <= addr_q;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (count_q != '0);
  assign instr_out   = instr_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];

endmodule
